// File: rtl/sdio_wb_arbiter_if.sv
// Wishbone bus bundle shared by the arbiter's two master ports and its slave-side port.
// The master modport is the initiator's view and the slave modport is the target's view.
interface sdio_wb_arbiter_if #(
    parameter int ADR_W = 8,
    parameter int DAT_W = 32
);
    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_w;
    logic [DAT_W-1:0] dat_r;
    logic             ack;
    logic             err;

    modport master (output cyc, stb, we, adr, dat_w, input  dat_r, ack, err);
    modport slave  (input  cyc, stb, we, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/sdio_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the sd_top slave port.
// The grant is held for a whole cyc, and a stalled strobe turns into an error reply.
module sdio_wb_arbiter #(
    parameter int ADR_W   = 8,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    sdio_wb_arbiter_if.slave  m0,
    sdio_wb_arbiter_if.slave  m1,
    sdio_wb_arbiter_if.master s,
    output logic [1:0]        grant_o
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, ERR, DRAIN} state_e;

    state_e           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;

    logic             own_cyc, own_stb, own_we;
    logic [ADR_W-1:0] own_adr;
    logic [DAT_W-1:0] own_dat;

    always_comb begin
        if (grant_q[1]) begin
            own_cyc = m1.cyc;
            own_stb = m1.stb;
            own_we  = m1.we;
            own_adr = m1.adr;
            own_dat = m1.dat_w;
        end else begin
            own_cyc = m0.cyc;
            own_stb = m0.stb;
            own_we  = m0.we;
            own_adr = m0.adr;
            own_dat = m0.dat_w;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        tmo_d    = tmo_q;
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = '0;
        s.dat_w  = '0;
        m0.ack   = 1'b0;
        m1.ack   = 1'b0;
        m0.err   = 1'b0;
        m1.err   = 1'b0;
        m0.dat_r = '0;
        m1.dat_r = '0;

        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                // last_q names the previous winner; a tie goes to the other master.
                if (m0.cyc && m1.cyc) begin
                    grant_d = last_q ? 2'b01 : 2'b10;
                    last_d  = ~last_q;
                    state_d = BUSY;
                end else if (m0.cyc) begin
                    grant_d = 2'b01;
                    last_d  = 1'b0;
                    state_d = BUSY;
                end else if (m1.cyc) begin
                    grant_d = 2'b10;
                    last_d  = 1'b1;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                s.cyc    = own_cyc;
                s.stb    = own_stb;
                s.we     = own_we;
                s.adr    = own_adr;
                s.dat_w  = own_dat;
                m0.dat_r = s.dat_r;
                m1.dat_r = s.dat_r;
                m0.ack   = s.ack & grant_q[0] & m0.stb;
                m1.ack   = s.ack & grant_q[1] & m1.stb;
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    tmo_d   = '0;
                end else if (TIMEOUT > 0 && own_stb && !s.ack) begin
                    // An ack in the terminal-count cycle takes this branch's else arm.
                    if (tmo_q == CNT_LAST) begin
                        state_d = ERR;
                        tmo_d   = '0;
                    end else if (tmo_q != '1) begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end else begin
                    tmo_d = '0;
                end
            end

            ERR: begin
                m0.err  = grant_q[0];
                m1.err  = grant_q[1];
                state_d = DRAIN;
            end

            DRAIN: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grant_o = grant_q;
endmodule
